// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    // funct3 encodings for RV32I loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Byte-enable patterns before shifting to the addressed lane
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Stores have no unsigned variants, so the legal set differs by direction
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Natural alignment check keyed on the access size bits
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half from a bus word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[offset];
    // Halfwords are only ever at offset 0 or 2, so offset[1] picks the pair
    assign half_sel = {lanes[{offset[1], 1'b1}], lanes[{offset[1], 1'b0}]};

    // Extension according to the access kind; words pass straight through
    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns a pipeline access into one req/ack bus
// transaction, stalls until it completes, and flags faults with a DONE-cycle err.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    lsu_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [31:0]       baddr_reg, baddr_next;
    logic [3:0]        be_reg, be_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       ld_reg, ld_next;
    logic              err_reg, err_next;
    // Size/sign and lane offset of the in-flight access, needed at ack time
    logic [2:0]        f3_reg, f3_next;
    logic [1:0]        off_reg, off_next;

    logic              access;
    logic              ok;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [31:0]       aligned_data;

    assign access = mem_rd | mem_wr;
    assign ok     = f3_legal(funct3, mem_wr) && f3_aligned(funct3, addr[1:0]);

    // Lane placement of enables and store data for the requested size
    always_comb begin
        be_calc    = BE_W;
        wdata_calc = st_data;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = BE_B << addr[1:0];
                wdata_calc = {4{st_data[7:0]}};
            end
            2'b01: begin
                be_calc    = BE_H << addr[1:0];
                wdata_calc = {2{st_data[15:0]}};
            end
            default: begin
                be_calc    = BE_W;
                wdata_calc = st_data;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata  (bus_rdata),
        .offset (off_reg),
        .funct3 (f3_reg),
        .data   (aligned_data)
    );

    // Next-state and next-output logic; err defaults low so it pulses once
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        baddr_next = baddr_reg;
        be_next    = be_reg;
        wdata_next = wdata_reg;
        ld_next    = ld_reg;
        err_next   = 1'b0;
        f3_next    = f3_reg;
        off_next   = off_reg;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    if (ok) begin
                        req_next   = 1'b1;
                        we_next    = mem_wr;
                        baddr_next = {addr[31:2], 2'b00};
                        be_next    = be_calc;
                        wdata_next = wdata_calc;
                        f3_next    = funct3;
                        off_next   = addr[1:0];
                        cnt_next   = '0;
                        state_next = BUSY;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                // ack is tested first so it wins over a coincident timeout
                if (bus_ack) begin
                    req_next   = 1'b0;
                    be_next    = 4'd0;
                    if (!we_reg)
                        ld_next = aligned_data;
                    state_next = DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    ld_next    = 32'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counter and registered bus/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            baddr_reg <= 32'd0;
            be_reg    <= 4'd0;
            wdata_reg <= 32'd0;
            ld_reg    <= 32'd0;
            err_reg   <= 1'b0;
            f3_reg    <= 3'd0;
            off_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            baddr_reg <= baddr_next;
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
            ld_reg    <= ld_next;
            err_reg   <= err_next;
            f3_reg    <= f3_next;
            off_reg   <= off_next;
        end
    end

    assign stall     = ((state_reg == IDLE) && access) || (state_reg == BUSY);
    assign ld_data   = ld_reg;
    assign err       = err_reg;
    assign bus_req   = req_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = baddr_reg;
    assign bus_be    = be_reg;
    assign bus_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against a behavioural model.
module tb_mem_lsu;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data;
    logic        stall;
    logic [31:0] ld_data;
    logic        err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int          vectors = 0;
    int          miscompares = 0;
    int          txn = 0;
    logic [31:0] model_ld;

    mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .funct3    (funct3),
        .addr      (addr),
        .st_data   (st_data),
        .stall     (stall),
        .ld_data   (ld_data),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- behavioural reference model ----
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_m(input bit wr, input logic [2:0] f3);
        if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input int o);
        int sz = size_of(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << o);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(f3);
        if (sz == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int o, input logic [2:0] f3);
        int sz = size_of(f3);
        longint v, lim;
        if (sz == 4) return rd;
        lim = longint'(1) << (8 * sz);
        v = longint'(rd >> (8 * o)) % lim;
        if (!f3[2] && v >= lim / 2) v = v - lim;
        return 32'(v);
    endfunction

    // One complete access; called and returns at a falling edge.
    // ack_at < 0 withholds the ack entirely.
    task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int ack_at, input logic [31:0] rdata);
        bit fault, timed_out, acked;
        int o;
        int busy_cycles;
        o = int'(a[1:0]);
        fault = !legal_m(wr, f3) || ((o % size_of(f3)) != 0);
        timed_out = 1'b0;
        acked = 1'b0;
        busy_cycles = 0;
        mem_rd = !wr; mem_wr = wr; funct3 = f3; addr = a; st_data = sd;
        #1;
        chk("stall_c0", stall, 1'b1);
        chk("req_c0", bus_req, 1'b0);
        @(negedge clk);
        if (!fault) begin
            chk("req_c1", bus_req, 1'b1);
            chk("we_c1", bus_we, wr);
            chk("addr_c1", bus_addr, {a[31:2], 2'b00});
            chk("be_c1", bus_be, exp_be(f3, o));
            if (wr) chk("wdata_c1", bus_wdata, exp_wdata(f3, sd));
            for (int k = 0; k < TIMEOUT; k++) begin
                chk("req_busy", bus_req, 1'b1);
                chk("stall_busy", stall, 1'b1);
                busy_cycles++;
                if (k == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end else begin
                    bus_rdata = $urandom;
                end
                @(negedge clk);
                bus_ack = 1'b0;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            timed_out = !acked;
            if (timed_out) model_ld = 32'd0;
            else if (!wr) model_ld = exp_load(rdata, o, f3);
        end
        // DONE cycle
        chk("req_done", bus_req, 1'b0);
        chk("err_done", err, (fault || timed_out) ? 1'b1 : 1'b0);
        chk("stall_done", stall, 1'b0);
        chk("ld_done", ld_data, model_ld);
        if (acked) chk("be_done", bus_be, 4'd0);
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        chk("err_idle", err, 1'b0);
        chk("stall_idle", stall, 1'b0);
        chk("req_idle", bus_req, 1'b0);
        txn++;
        $display("txn %0d: %s f3=%0d addr=%h sd=%h busy=%0d fault=%0b timeout=%0b ld=%h",
                 txn, wr ? "ST" : "LD", f3, a, sd, busy_cycles, fault, timed_out, ld_data);
    endtask

    initial begin
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;

        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0; addr = 32'd0;
        st_data = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
        model_ld = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", bus_be, 4'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
        chk("plan_lw", ld_data, 32'hDEAD_BEEF);
        run_access(1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, 32'h80FF_0000);
        chk("plan_lb", ld_data, 32'hFFFF_FF80);
        run_access(1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, 32'h80FF_0000);
        chk("plan_lbu", ld_data, 32'h0000_0080);
        run_access(1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 1, 32'd0);
        chk("plan_sh_ld", ld_data, 32'h0000_0080);
        run_access(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'd0);
        run_access(1'b1, 3'b100, 32'h0000_0400, 32'h5555_5555, 0, 32'd0);
        run_access(1'b0, 3'b011, 32'h0000_0400, 32'd0, 0, 32'd0);
        run_access(1'b0, 3'b010, 32'h0000_0500, 32'd0, 0, 32'hCAFE_F00D);
        run_access(1'b0, 3'b010, 32'h0000_0600, 32'd0, -1, 32'd0);
        chk("plan_timeout_ld", ld_data, 32'd0);
        run_access(1'b0, 3'b101, 32'h0000_0702, 32'd0, TIMEOUT - 1, 32'h8765_4321);
        chk("plan_lastack_ld", ld_data, 32'h0000_8765);

        // Reset while BUSY, then a stray ack
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0800;
        @(negedge clk);
        chk("midrst_req_busy", bus_req, 1'b1);
        rst = 1'b1; mem_rd = 1'b0;
        @(negedge clk);
        model_ld = 32'd0;
        chk("midrst_req", bus_req, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_ld", ld_data, 32'd0);
        chk("midrst_be", bus_be, 4'd0);
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_req", bus_req, 1'b0);
        chk("stray_ld", ld_data, 32'd0);
        chk("stray_err", err, 1'b0);
        @(negedge clk);
        chk("stray_ld2", ld_data, 32'd0);
        chk("stray_stall", stall, 1'b0);

        // Randomized accesses, mostly aligned and legal
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~(32'(size_of(f3)) - 32'd1);
            run_access(wr, f3, a, $urandom, int'($urandom_range(0, 4)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit of the RV32I pipeline, directly upstream of the MEM/WB register.
- Converts the EX/MEM access request into a word-aligned req/ack data-bus transaction with byte enables and stalls the pipeline until the access completes.
- For loads, sign- or zero-extends the returned data and presents it on ld_data for the MEM/WB register to capture.
- Flags misaligned accesses, illegal funct3 and bus timeouts.

Parameters:
- TIMEOUT, 64: cycles in BUSY without bus_ack before the access is aborted; must be ≥2.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_rd  in  1  load request from EX/MEM
- mem_wr  in  1  store request from EX/MEM; mem_rd and mem_wr are never both 1
- funct3  in  3  access size/sign
- addr  in  32  byte address (alu_out)
- st_data  in  32  store data, right-justified
- stall  out  1  hold PC/IF/ID/EX/MEM registers
- ld_data  out  32  extended load result, registered
- err  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion

Behaviour:
- Reset (synchronous, active-high; at any rising edge with rst=1, including mid-transaction):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - ld_data=0, err=0, timeout counter=0.
- access = mem_rd|mem_wr.
- stall = (state==IDLE && access) || state==BUSY. stall is combinational; it is low in DONE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE, access && legal && aligned:
  - Register bus_req=1, bus_we=mem_wr, bus_addr, bus_be, bus_wdata.
  - Clear the counter; go BUSY.
- IDLE, access && (illegal || misaligned):
  - No bus request; err=1 next cycle.
  - ld_data unchanged; go DONE.
- BUSY:
  - Outputs are held stable while bus_req=1.
  - Each cycle without bus_ack, the counter increments.
  - On bus_ack: bus_req=0, bus_be=0; if load, ld_data ← extend(bus_rdata). Go DONE.
  - On counter==TIMEOUT-1 without ack: bus_req=0, err=1, ld_data=0; go DONE.
  - If ack and timeout coincide, ack wins: no err.
- DONE: stall=0, so the pipeline advances at the end of this cycle. err is held for exactly this cycle. Go IDLE.
- err is therefore high only in the DONE cycle of a faulting access.
- A bus_ack outside BUSY is ignored.
- Byte enables and lanes (o = addr[1:0]):
  - SB: bus_be = 0001<<o; wdata = {4{st_data[7:0]}}.
  - SH: bus_be = 0011<<o; wdata = {2{st_data[15:0]}}.
  - SW: bus_be = 1111; wdata = st_data.
  - Loads use the same be pattern for their size.
- Load extension: the byte/half is selected at offset o from bus_rdata and sign-extended (LB/LH) or zero-extended (LBU/LHU).
- ld_data holds its value between loads; stores do not modify it.
- Minimum latency: the access is seen in cycle 0, bus_req is high in cycle 1, and ack in cycle 1 makes cycle 2 the DONE cycle. An access therefore costs 2 stall cycles plus the ack wait.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle after DONE.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding IDLE/BUSY/DONE (2 bits).
  - Byte-enable base constants.
- Sub-module lsu_load_align: combinational; inputs rdata, offset, funct3; output the 32-bit extended value. Instantiated once.
- FSM, counter and bus registers stay in mem_lsu.

Test Plan:
- LW at 0x100, ack in cycle 1, rdata=0xDEADBEEF:
  - bus_addr=0x100, be=1111, bus_we=0.
  - stall high for 2 cycles; ld_data=0xDEADBEEF in DONE; err=0.
- LB at 0x203 with rdata=0x80FF_0000 → be=1000, ld_data=0xFFFFFF80. Same access as LBU → ld_data=0x00000080.
- SH at 0x302, st_data=0x1234ABCD:
  - be=1100, bus_wdata=0xABCDABCD, bus_we=1.
  - ld_data unchanged.
- LW at 0x101 → no bus_req ever asserted; err=1 in the single DONE cycle; stall high for exactly 1 cycle.
- LW, ack withheld, TIMEOUT=64 → bus_req drops after 64 BUSY cycles; err=1 and ld_data=0 in DONE. Repeat with ack on the final BUSY cycle → ack wins, err=0.
- rst=1 while in BUSY → next cycle bus_req=0, state IDLE, stall=0; a subsequent ack is ignored.
